// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the pipeline and the HI/LO multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] rdata_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i,
        input  busy_o, stall_o, done_o, rdata_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i,
        output busy_o, stall_o, done_o, rdata_o, hi_o, lo_o
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO registers.
// Signed ops run on magnitudes; signs are re-applied in a single FIX cycle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            reset_n,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [WIDTH-1:0]     r_rdata;
    logic [WIDTH-1:0]     r_opd;
    logic [WIDTH-1:0]     r_a_raw;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_done;
    logic                 r_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_dz;

    logic                 w_signed;
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH+1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_q_fix;
    logic [WIDTH-1:0]     w_r_fix;

    assign w_signed = bus.op_i[1];
    assign w_a_neg  = w_signed && bus.a_i[WIDTH-1];
    assign w_b_neg  = w_signed && bus.b_i[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -bus.a_i : bus.a_i;
    assign w_b_mag  = w_b_neg ? -bus.b_i : bus.b_i;

    // Multiply: acc = {partial, multiplier}, add multiplicand when LSB set.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_opd} : '0);
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, trial-subtract shifted rem.
    assign w_diff     = {1'b0, r_acc[2*WIDTH-1:WIDTH-1]} - {2'b00, r_opd};
    assign w_div_next = w_diff[WIDTH+1]
                      ? {r_acc[2*WIDTH-2:0], 1'b0}
                      : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_q_fix    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_r_fix    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH]
                                : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_rdata <= '0;
            r_opd   <= '0;
            r_a_raw <= '0;
            r_acc   <= '0;
            r_done  <= 1'b0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start_i && !bus.op_i[2]) begin
                        r_state <= S_RUN;
                        r_cnt   <= CW'(WIDTH - 1);
                        r_div   <= !bus.op_i[0];
                        r_a_raw <= bus.a_i;
                        r_dz    <= !bus.op_i[0] && (bus.b_i == '0);
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        if (bus.op_i[0]) begin
                            r_opd <= w_a_mag;
                            r_acc <= {{WIDTH{1'b0}}, w_b_mag};
                        end else begin
                            r_opd <= w_b_mag;
                            r_acc <= {{WIDTH{1'b0}}, w_a_mag};
                        end
                    end else if (bus.start_i) begin
                        unique case (bus.op_i[1:0])
                            2'b00: r_hi    <= bus.a_i;
                            2'b01: r_lo    <= bus.a_i;
                            2'b10: r_rdata <= r_hi;
                            2'b11: r_rdata <= r_lo;
                        endcase
                    end
                end
                S_RUN: begin
                    r_acc <= r_div ? w_div_next : w_mul_next;
                    if (r_cnt == '0) r_state <= S_FIX;
                    else             r_cnt   <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                    if (r_dz) begin
                        r_hi <= r_a_raw;
                        r_lo <= '1;
                    end else if (r_div) begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o  = (r_state != S_IDLE);
    assign bus.stall_o = bus.start_i && bus.busy_o;
    assign bus.done_o  = r_done;
    assign bus.rdata_o = r_rdata;
    assign bus.hi_o    = r_hi;
    assign bus.lo_o    = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors, random ops
// against an arithmetic model, and handshake/reset corner sequences.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(32)) b32();
    mult_div_unit_if #(.WIDTH(8))  b8();

    mult_div_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(b32));
    mult_div_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(b8));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        string       nm;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values, returns {HI,LO}.
    function automatic logic [63:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (op)
            3'b001: res = {32'd0, a} * {32'd0, b};
            3'b011: res = sa * sb;
            3'b000: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            3'b010: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    res = {32'd0, 32'h8000_0000};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic run32(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input string nm);
        int cnt;
        @(negedge clk);
        b32.start_i = 1'b1;
        b32.op_i    = op;
        b32.a_i     = a;
        b32.b_i     = b;
        @(negedge clk);
        b32.start_i = 1'b0;
        b32.a_i     = $urandom;
        b32.b_i     = $urandom;
        cnt = 0;
        while (b32.busy_o && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk({nm, " busy_cycles"}, 64'(cnt), 64'd33);
        chk({nm, " done"}, 64'(b32.done_o), 64'd1);
        chk({nm, " hilo"}, {b32.hi_o, b32.lo_o}, exp);
        @(negedge clk);
        chk({nm, " done_pulse"}, 64'(b32.done_o), 64'd0);
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp,
                        input string nm);
        int cnt;
        @(negedge clk);
        b8.start_i = 1'b1;
        b8.op_i    = op;
        b8.a_i     = a;
        b8.b_i     = b;
        @(negedge clk);
        b8.start_i = 1'b0;
        cnt = 0;
        while (b8.busy_o && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk({nm, " busy_cycles"}, 64'(cnt), 64'd9);
        chk({nm, " done"}, 64'(b8.done_o), 64'd1);
        chk({nm, " hilo"}, 64'({b8.hi_o, b8.lo_o}), 64'(exp));
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] rexp;
        int cnt;

        tv[0] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  {32'hFFFF_FFFE, 32'h0000_0001}, "multu_max"};
        tv[1] = '{3'b011, 32'hFFFF_FFFD, 32'd7,
                  {32'hFFFF_FFFF, 32'hFFFF_FFEB}, "mult_neg"};
        tv[2] = '{3'b010, 32'hFFFF_FFF9, 32'd2,
                  {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg"};
        tv[3] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF,
                  {32'h0000_0000, 32'h8000_0000}, "div_ovf"};
        tv[4] = '{3'b000, 32'd7, 32'd0,
                  {32'h0000_0007, 32'hFFFF_FFFF}, "divu_zero"};
        tv[5] = '{3'b000, 32'd100, 32'd3,
                  {32'd1, 32'd33}, "divu_100_3"};
        tv[6] = '{3'b010, 32'd7, 32'hFFFF_FFFE,
                  {32'd1, 32'hFFFF_FFFD}, "div_negb"};
        tv[7] = '{3'b010, 32'hFFFF_FFF9, 32'd0,
                  {32'hFFFF_FFF9, 32'hFFFF_FFFF}, "div_zero"};

        reset_n    = 1'b0;
        b32.start_i = 1'b0;
        b32.op_i    = '0;
        b32.a_i     = '0;
        b32.b_i     = '0;
        b8.start_i  = 1'b0;
        b8.op_i     = '0;
        b8.a_i      = '0;
        b8.b_i      = '0;
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(b32.busy_o), 64'd0);
        chk("rst done", 64'(b32.done_o), 64'd0);
        chk("rst stall", 64'(b32.stall_o), 64'd0);
        chk("rst rdata", 64'(b32.rdata_o), 64'd0);
        chk("rst hilo", {b32.hi_o, b32.lo_o}, 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run32(tv[i].op, tv[i].a, tv[i].b, tv[i].exp, tv[i].nm);

        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 7 == 3) rb = 32'd0;
            if (i % 5 == 1) rb = 32'($urandom_range(1, 20));
            if (i % 9 == 4) ra = 32'h8000_0000;
            rexp = model(rop, ra, rb);
            run32(rop, ra, rb, rexp, "random");
        end

        // MTHI then MFHI back-to-back; neither may raise busy
        @(negedge clk);
        b32.start_i = 1'b1;
        b32.op_i    = 3'b100;
        b32.a_i     = 32'h0000_1234;
        @(negedge clk);
        chk("mthi busy", 64'(b32.busy_o), 64'd0);
        chk("mthi hi", 64'(b32.hi_o), 64'h1234);
        b32.op_i = 3'b110;
        b32.a_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        b32.start_i = 1'b0;
        chk("mfhi busy", 64'(b32.busy_o), 64'd0);
        chk("mfhi rdata", 64'(b32.rdata_o), 64'h1234);

        // MFLO held while a MULT is in flight
        rexp = model(3'b011, 32'hFFFF_FFFD, 32'd7);
        @(negedge clk);
        b32.start_i = 1'b1;
        b32.op_i    = 3'b011;
        b32.a_i     = 32'hFFFF_FFFD;
        b32.b_i     = 32'd7;
        @(negedge clk);
        b32.start_i = 1'b0;
        repeat (4) @(negedge clk);
        b32.start_i = 1'b1;
        b32.op_i    = 3'b111;
        #1;
        chk("mflo stall", 64'(b32.stall_o), 64'd1);
        cnt = 0;
        while (b32.busy_o && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("mflo stall_drop", 64'(b32.stall_o), 64'd0);
        chk("mflo done", 64'(b32.done_o), 64'd1);
        chk("mflo rdata_old", 64'(b32.rdata_o), 64'h1234);
        @(negedge clk);
        b32.start_i = 1'b0;
        chk("mflo rdata", 64'(b32.rdata_o), 64'(rexp[31:0]));
        chk("mflo busy", 64'(b32.busy_o), 64'd0);

        // Reset mid-divide discards everything
        @(negedge clk);
        b32.start_i = 1'b1;
        b32.op_i    = 3'b000;
        b32.a_i     = 32'd100;
        b32.b_i     = 32'd3;
        @(negedge clk);
        b32.start_i = 1'b0;
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst busy", 64'(b32.busy_o), 64'd0);
        chk("midrst hilo", {b32.hi_o, b32.lo_o}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (b32.done_o || b32.busy_o) begin
                chk("midrst no_done", {62'd0, b32.done_o, b32.busy_o}, 64'd0);
                break;
            end
        end
        chk("midrst hold", {b32.hi_o, b32.lo_o}, 64'd0);
        run32(3'b000, 32'd100, 32'd3, {32'd1, 32'd33}, "divu_after_rst");

        run8(3'b011, 8'h80, 8'h80, 16'h4000, "w8_mult");
        run8(3'b010, 8'h81, 8'h02, 16'hFFC1, "w8_div");
        run8(3'b001, 8'hFF, 8'hFF, 16'hFE01, "w8_multu");
        run8(3'b000, 8'hFF, 8'h00, 16'hFFFF, "w8_divu_zero");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit holding the architectural HI/LO registers. It executes the 3-bit multiply/divide operation code produced by the ALU control decoder: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. It replaces single-cycle mult/div with a WIDTH-parametrised shift-add/restoring datapath and a busy/stall handshake toward the pipeline.

Parameters:
WIDTH, 32, operand, HI and LO width in bits (must be >= 4)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous, active-low reset
start_i  input  1  request to execute op_i this cycle
op_i  input  3  000 DIVU, 001 MULTU, 010 DIV, 011 MULT, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
a_i  input  WIDTH  operand rs (dividend / multiplicand / MT source)
b_i  input  WIDTH  operand rt (divisor / multiplier)
busy_o  output  1  iterative operation in progress
stall_o  output  1  combinational; start_i & busy_o
done_o  output  1  one-cycle pulse when a MULT/DIV result is written to HI/LO
rdata_o  output  WIDTH  MFHI/MFLO read data
hi_o  output  WIDTH  current HI register
lo_o  output  WIDTH  current LO register

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state IDLE; HI=LO=0; counter=0.
  - busy_o=0, done_o=0, stall_o=0, rdata_o=0.
  - Any in-flight operation is discarded. HI/LO keep no partial result.
- States: IDLE, RUN, FIX.
- IDLE:
  - start_i with MULT/MULTU/DIV/DIVU: latch operands at the edge, then go to RUN with counter=WIDTH-1.
    - Signed ops latch magnitudes and record the result signs.
    - Unsigned ops latch operands as given.
  - start_i with MTHI/MTLO: write a_i to HI/LO at that edge. Stay in IDLE; no busy, no done.
  - MFHI/MFLO: no state change.
- RUN:
  - One iteration per cycle, WIDTH cycles total.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - After the iteration with counter=0, go to FIX.
- FIX (one cycle):
  - Apply sign correction and write HI/LO at the edge leaving FIX.
  - Assert done_o for the cycle following that edge; state returns to IDLE.
- busy_o:
  - Asserted in RUN and FIX: exactly WIDTH+1 cycles after the accepting edge.
  - done_o coincides with the first cycle of busy_o=0.
- Multiply results:
  - {HI,LO} = full 2*WIDTH-bit product.
  - Signed: negate (two's complement, 2*WIDTH bits) when the operand signs differ.
- Divide results:
  - LO = quotient, HI = remainder.
  - Signed: quotient negative iff the operand signs differ; remainder takes the dividend's sign (truncating division).
- Divide by zero (b_i=0, signed or unsigned): LO = all ones, HI = a_i as given; no sign correction.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- rdata_o:
  - Registered, updated at the edge where MFHI/MFLO is accepted (start_i & ~busy_o).
  - MFHI returns HI, MFLO returns LO.
  - A same-edge MTHI/MTLO is not possible (one op per cycle). The value read is the register content before that edge.
  - Data is valid the cycle after acceptance.
- While busy:
  - Every start_i is ignored, including MT and MF, and stall_o=1.
  - The pipeline must hold the request until stall_o drops.
  - A request held through FIX is accepted on the edge after done_o's cycle begins; it sees the new HI/LO.
- Operand inputs are ignored outside the accepting edge. Changes during RUN have no effect.
- Reset asserted mid-RUN/FIX: immediate IDLE, HI=LO=0, no done_o.

Test Plan:
1. WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy_o high 33 cycles, then done_o pulse; HI=0xFFFFFFFE, LO=0x00000001.
2. MULT a=0xFFFFFFFD (-3) b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
3. DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
   - DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
4. MTHI a=0x00001234, next cycle MFHI -> rdata_o=0x00001234 one cycle later, busy_o never set.
   - Then start MULT and issue MFLO 5 cycles later -> stall_o=1 until busy_o falls; rdata_o equals the new LO.
5. Start DIVU 100/3, assert reset_n=0 at iteration 10 -> HI=LO=0, busy_o=0 immediately, no done_o.
   - After release, DIVU 100/3 -> LO=33, HI=1.
6. WIDTH=8, MULT a=0x80 b=0x80 -> busy_o high 9 cycles; HI=0x40, LO=0x00.
   - DIV 0x81 (-127) / 0x02 -> LO=0xC1, HI=0xFF.
